// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: FSM state encoding and
// the mode LED patterns shown for each state.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'b00,
        ST_PLAYBACK = 2'b01,
        ST_REPEAT   = 2'b10,
        ST_DONE     = 2'b11
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

    function automatic logic [2:0] mode_of(input state_t st);
        logic [2:0] leds;
        case (st)
            ST_INPUT:    leds = LED_MODE_INPUT;
            ST_PLAYBACK: leds = LED_MODE_PLAYBACK;
            ST_REPEAT:   leds = LED_MODE_REPEAT;
            ST_DONE:     leds = LED_MODE_DONE;
            default:     leds = LED_MODE_INPUT;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/simon_control.sv
// Simon game control FSM: sequences entry, playback and repeat of the stored
// pattern list, and drives the datapath counter/memory strobes combinationally.
module simon_control
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pattern_valid,
    input  logic       pattern_eq_mem,
    input  logic       index_lt_count,
    output logic       count_cnt,
    output logic       count_clr,
    output logic       index_cnt,
    output logic       index_clr,
    output logic       write_en,
    output logic       load_level,
    output logic       disp_mem,
    output logic [2:0] mode_leds
);

    state_t state_r;
    state_t state_next_s;
    logic   match_s;

    // An illegal pattern can never count as a correct repeat.
    assign match_s   = pattern_eq_mem & pattern_valid;
    assign mode_leds = mode_of(state_r);

    // State register, forced to INPUT asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INPUT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes from current state and inputs.
    always_comb begin
        state_next_s = state_r;
        count_cnt    = 1'b0;
        count_clr    = 1'b0;
        index_cnt    = 1'b0;
        index_clr    = 1'b0;
        write_en     = 1'b0;
        load_level   = 1'b0;
        disp_mem     = 1'b0;

        if (rst) begin
            // Any clock edge seen during reset clears the datapath and takes the level.
            state_next_s = ST_INPUT;
            count_clr    = 1'b1;
            index_clr    = 1'b1;
            load_level   = 1'b1;
        end else begin
            case (state_r)
                ST_INPUT: begin
                    if (pattern_valid) begin
                        write_en     = 1'b1;
                        index_clr    = 1'b1;
                        state_next_s = ST_PLAYBACK;
                    end else begin
                        state_next_s = ST_INPUT;
                    end
                end
                ST_PLAYBACK: begin
                    disp_mem = 1'b1;
                    if (index_lt_count) begin
                        index_cnt = 1'b1;
                    end else begin
                        index_clr    = 1'b1;
                        state_next_s = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (!match_s) begin
                        index_clr    = 1'b1;
                        state_next_s = ST_DONE;
                    end else if (index_lt_count) begin
                        index_cnt = 1'b1;
                    end else begin
                        count_cnt    = 1'b1;
                        state_next_s = ST_INPUT;
                    end
                end
                ST_DONE: begin
                    // Loop the stored sequence on the LEDs until reset.
                    disp_mem = 1'b1;
                    if (index_lt_count) begin
                        index_cnt = 1'b1;
                    end else begin
                        index_clr = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_INPUT;
                end
            endcase
        end
    end

endmodule

// File: doc/simon_control.md
SIMON_CONTROL -- requirements
Module: simon_control

Interface
REQ-001 clk  input  1  single clock, rising-edge; every state change happens on this edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 pattern_valid  input  1  current switch pattern is legal for the loaded level.
REQ-004 pattern_eq_mem  input  1  current switch pattern equals mem[index].
REQ-005 index_lt_count  input  1  index < count in datapath.
REQ-006 count_cnt, count_clr  output  1 each  count counter increment/synchronous clear.
REQ-007 index_cnt, index_clr  output  1 each  index counter increment/synchronous clear.
REQ-008 write_en  output  1  write pattern into mem[count] on this edge.
REQ-009 load_level  output  1  latch level switch into datapath.
REQ-010 disp_mem  output  1  drive pattern_leds from mem[index] (else from pattern).
REQ-011 mode_leds  output  3  game mode: INPUT 3'b001, PLAYBACK 3'b010, REPEAT 3'b100, DONE 3'b111.

Function
REQ-012 The FSM SHALL have exactly four states: INPUT, PLAYBACK, REPEAT, DONE.
REQ-013 mode_leds SHALL be a Moore function of the state only; all other outputs SHALL be combinational from state and inputs (zero-cycle latency).
REQ-014 Outputs not listed as asserted in a state or condition SHALL be 0.
REQ-015 INPUT: disp_mem=0; if pattern_valid, write_en=1, index_clr=1, next=PLAYBACK; else stay and no write.
REQ-016 PLAYBACK: disp_mem=1; if index_lt_count, index_cnt=1 and stay; else index_clr=1, next=REPEAT.
REQ-017 REPEAT: disp_mem=0; if !pattern_eq_mem, index_clr=1, next=DONE.
REQ-018 REPEAT: if pattern_eq_mem and index_lt_count, index_cnt=1 and stay.
REQ-019 REPEAT: if pattern_eq_mem and !index_lt_count (last entry matched), count_cnt=1, next=INPUT.
REQ-020 Mismatch SHALL take priority over the last-entry match in REPEAT; an invalid pattern in REPEAT SHALL be treated as a mismatch.
REQ-021 DONE: disp_mem=1; the FSM SHALL cycle the stored sequence: if index_lt_count, index_cnt=1; else index_clr=1; DONE SHALL be left only by reset.
REQ-022 Count semantics: count SHALL equal the index of the most recently written entry; in a round with N entries, PLAYBACK and REPEAT SHALL each last N cycles.
REQ-023 cnt and clr of the same counter SHALL never be asserted together.
REQ-024 load_level SHALL be asserted only during reset; level changes after reset SHALL have no effect.
REQ-025 Wrap of the 6-bit count after 64 rounds is owned by the datapath; the FSM SHALL continue operating unchanged.

Reset
REQ-026 While rst=1, state SHALL be forced asynchronously to INPUT; mode_leds SHALL read 3'b001.
REQ-027 While rst=1, count_clr, index_clr and load_level SHALL be 1 and all other controls SHALL be 0, so that a clk edge during reset clears the datapath.
REQ-028 Reset asserted mid-round (any state) SHALL abandon the round with no write_en or cnt pulse.

Structure
REQ-029 The state encoding and LED_MODE_* constants SHALL live in shared package simon_pkg, which is also used by the top level and the bench.
REQ-030 No sub-module is required: one state register plus a combinational next-state/output block, instantiated beside SimonDatapath in the top level.

Verification
REQ-031 rst=1, then pulse clk -> count_clr=index_clr=load_level=1 and mode_leds=001; after release, the FSM is in INPUT with all controls 0.
REQ-032 INPUT with pattern_valid=0, 3 clocks -> stays in INPUT, write_en never 1; with pattern_valid=1 -> write_en=1, index_clr=1, then PLAYBACK (010).
REQ-033 PLAYBACK with index_lt_count=1,1,0 -> index_cnt=1,1 then index_clr=1, disp_mem=1 throughout, then REPEAT (100).
REQ-034 REPEAT with pattern_eq_mem=1 and index_lt_count=1, then eq=1 and lt=0 -> index_cnt=1, then count_cnt=1, then INPUT (001).
REQ-035 REPEAT with pattern_eq_mem=0 (with index_lt_count either 0 or 1) -> index_clr=1, DONE (111); DONE holds for 10 clocks with disp_mem=1 and index cycling.
REQ-036 Async rst asserted between clock edges in PLAYBACK -> mode_leds=001 immediately, with no count_cnt or write_en pulse.
